// File: rtl/modsq_norm_pkg.sv
// Shared constants, state encoding and carry-bound helper for the squarer-output normalizer.
package modsq_norm_pkg;

    localparam int unsigned DEFAULT_WORD_LEN     = 16;
    localparam int unsigned DEFAULT_BIT_LEN      = 17;
    localparam int unsigned DEFAULT_NUM_ELEMENTS = 66;
    localparam int unsigned DEFAULT_LANES        = 6;
    localparam int unsigned DEFAULT_CARRY_LEN    = 2;
    localparam int unsigned NUM_CHUNKS           = DEFAULT_NUM_ELEMENTS / DEFAULT_LANES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Fixed point of carry = (max_coeff + carry) >> word_len: the largest carry the chain can produce.
    function automatic int unsigned max_carry(input int unsigned word_len, input int unsigned bit_len);
        longint unsigned c;
        c = 64'd0;
        for (int i = 0; i < 64; i++) begin
            c = ((64'd1 << bit_len) - 64'd1 + c) >> word_len;
        end
        return 32'(c);
    endfunction

endpackage

// File: rtl/modular_square_normalizer_lane.sv
// One redundant coefficient plus incoming carry resolved into a canonical word and outgoing carry.
module coef_carry_lane
    import modsq_norm_pkg::*;
#(
    parameter int unsigned WORD_LEN  = DEFAULT_WORD_LEN,
    parameter int unsigned BIT_LEN   = DEFAULT_BIT_LEN,
    parameter int unsigned CARRY_LEN = DEFAULT_CARRY_LEN
) (
    input  logic [BIT_LEN-1:0]   coef,
    input  logic [CARRY_LEN-1:0] carry_in,
    output logic [WORD_LEN-1:0]  word_c,
    output logic [CARRY_LEN-1:0] carry_out_c
);

    localparam int unsigned SUM_W = ((BIT_LEN > CARRY_LEN) ? BIT_LEN : CARRY_LEN) + 1;

    logic [SUM_W-1:0] sum;

    // Add carry, keep the low word, pass everything above it on.
    assign sum         = SUM_W'(coef) + SUM_W'(carry_in);
    assign word_c      = sum[WORD_LEN-1:0];
    assign carry_out_c = CARRY_LEN'(sum >> WORD_LEN);

endmodule

// File: rtl/modular_square_normalizer.sv
// Resolves redundant squarer coefficients into a canonical integer, LANES coefficients per cycle.
module modular_square_normalizer
    import modsq_norm_pkg::*;
#(
    parameter int unsigned WORD_LEN     = DEFAULT_WORD_LEN,
    parameter int unsigned BIT_LEN      = DEFAULT_BIT_LEN,
    parameter int unsigned NUM_ELEMENTS = DEFAULT_NUM_ELEMENTS,
    parameter int unsigned LANES        = DEFAULT_LANES,
    parameter int unsigned CARRY_LEN    = DEFAULT_CARRY_LEN
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [NUM_ELEMENTS*2*WORD_LEN-1:0] sq_in,
    output logic                             busy,
    output logic                             dropped,
    output logic                             out_valid,
    output logic [NUM_ELEMENTS*WORD_LEN-1:0] result,
    output logic [CARRY_LEN-1:0]             carry_out
);

    localparam int unsigned N_CHUNKS = NUM_ELEMENTS / LANES;
    localparam int unsigned IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int unsigned RES_W    = NUM_ELEMENTS * WORD_LEN;
    localparam int unsigned SR_W     = NUM_ELEMENTS * BIT_LEN;

    if (NUM_ELEMENTS % LANES != 0) begin : g_bad_lanes
        $error("NUM_ELEMENTS must be a multiple of LANES");
    end
    if ((64'd1 << CARRY_LEN) - 64'd1 < 64'(max_carry(WORD_LEN, BIT_LEN))) begin : g_bad_carry
        $error("CARRY_LEN too narrow for the worst-case carry");
    end

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [CARRY_LEN-1:0]       carry;
    logic [SR_W-1:0]            coef_sr;
    logic [RES_W-1:0]           work;
    logic [SR_W-1:0]            captured;
    logic [LANES*WORD_LEN-1:0]  chunk_words;
    logic [LANES:0][CARRY_LEN-1:0] chain;
    logic                       unused_sq;

    // Field bits above BIT_LEN are deliberately discarded.
    assign unused_sq = ^sq_in;

    // Strip each 2*WORD_LEN field down to its significant bits.
    always_comb begin
        captured = '0;
        for (int j = 0; j < int'(NUM_ELEMENTS); j++) begin
            captured[j*BIT_LEN +: BIT_LEN] = sq_in[j*2*WORD_LEN +: BIT_LEN];
        end
    end

    assign chain[0] = carry;

    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        coef_carry_lane #(
            .WORD_LEN  (WORD_LEN),
            .BIT_LEN   (BIT_LEN),
            .CARRY_LEN (CARRY_LEN)
        ) u_lane (
            .coef        (coef_sr[l*BIT_LEN +: BIT_LEN]),
            .carry_in    (chain[l]),
            .word_c      (chunk_words[l*WORD_LEN +: WORD_LEN]),
            .carry_out_c (chain[l+1])
        );
    end

    // Control FSM, chunk walk through the shift register, and commit of finished results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            dropped   <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= '0;
            idx       <= '0;
            carry     <= '0;
            coef_sr   <= '0;
            work      <= '0;
        end else begin
            dropped   <= in_valid && (state != IDLE);
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        coef_sr <= captured;
                        idx     <= '0;
                        carry   <= '0;
                        state   <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    coef_sr <= coef_sr >> (LANES * BIT_LEN);
                    work    <= RES_W'({chunk_words, work} >> (LANES * WORD_LEN));
                    carry   <= chain[LANES];
                    if (idx == IDX_W'(N_CHUNKS - 1)) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    result    <= work;
                    carry_out <= carry;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
